// File: rtl/bubble_ctrl_pkg.sv
// Shared definitions for the BUBBLE multi-cycle controller.
// Holds the opcode and funct constants, the FSM state enum, the ALU operation
// encoding, the pc_src/wb_sel/reg_dst codes, the instruction classes produced
// by the decoder, and a helper function that evaluates branch conditions.
package bubble_ctrl_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpBgt   = 6'b000111;
  localparam logic [5:0] OpBge   = 6'b001111;
  localparam logic [5:0] OpBlt   = 6'b000110;
  localparam logic [5:0] OpBle   = 6'b011111;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnSlt  = 6'b101010;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  // AluAdd is zero so an idle controller drives an all-zero alu_op.
  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAddu = 4'd2,
    AluSubu = 4'd3,
    AluAnd  = 4'd4,
    AluOr   = 4'd5,
    AluSll  = 4'd6,
    AluSrl  = 4'd7,
    AluSlt  = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    PcSeq    = 2'd0,  // PC+1
    PcBranch = 2'd1,  // PC+1+imm
    PcJump   = 2'd2,  // jump target
    PcRs     = 2'd3   // rs (jr)
  } pc_src_e;

  typedef enum logic [1:0] {
    WbAlu = 2'd0,
    WbMem = 2'd1,
    WbPc  = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    RegDstRt   = 2'd0,
    RegDstRd   = 2'd1,
    RegDstLink = 2'd2
  } reg_dst_e;

  typedef enum logic [3:0] {
    ClsIllegal = 4'd0,
    ClsRAlu    = 4'd1,
    ClsIAlu    = 4'd2,
    ClsLoad    = 4'd3,
    ClsStore   = 4'd4,
    ClsBranch  = 4'd5,
    ClsJump    = 4'd6,
    ClsJal     = 4'd7,
    ClsJr      = 4'd8
  } instr_class_e;

  typedef enum logic [2:0] {
    BrEq = 3'd0,
    BrNe = 3'd1,
    BrGt = 3'd2,
    BrGe = 3'd3,
    BrLt = 3'd4,
    BrLe = 3'd5
  } br_cond_e;

  typedef struct packed {
    instr_class_e cls;
    br_cond_e     br_cond;
    alu_op_e      alu_op;
    logic         alu_src_imm;
    logic         imm_zext;
    reg_dst_e     reg_dst;
    wb_sel_e      wb_sel;
    logic         illegal;
  } decode_t;

  // zero/neg come from the rs-rt compare performed in EXEC.
  function automatic logic branch_taken(br_cond_e cond, logic zero, logic neg);
    logic taken;
    case (cond)
      BrEq:    taken = zero;
      BrNe:    taken = ~zero;
      BrGt:    taken = ~zero & ~neg;
      BrGe:    taken = ~neg;
      BrLt:    taken = neg;
      BrLe:    taken = neg | zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/bubble_ctrl_decode.sv
// Combinational instruction classifier for the BUBBLE controller.
// Ports:
//   ir  - latched instruction register
//   dec - class, branch condition, ALU op, operand/immediate selects,
//         writeback destination/source and illegal flag
module bubble_ctrl_decode
  import bubble_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output decode_t     dec
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_ir_fields;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];
  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_ir_fields = ^ir[25:6];

  always_comb begin
    dec.cls         = ClsIllegal;
    dec.br_cond     = BrEq;
    dec.alu_op      = AluAdd;
    dec.alu_src_imm = 1'b0;
    dec.imm_zext    = 1'b0;
    dec.reg_dst     = RegDstRt;
    dec.wb_sel      = WbAlu;
    dec.illegal     = 1'b0;

    case (opcode)
      OpRtype: begin
        dec.cls     = ClsRAlu;
        dec.reg_dst = RegDstRd;
        case (funct)
          FnAdd:  dec.alu_op = AluAdd;
          FnSub:  dec.alu_op = AluSub;
          FnAddu: dec.alu_op = AluAddu;
          FnSubu: dec.alu_op = AluSubu;
          FnAnd:  dec.alu_op = AluAnd;
          FnOr:   dec.alu_op = AluOr;
          FnSll:  dec.alu_op = AluSll;
          FnSrl:  dec.alu_op = AluSrl;
          FnSlt:  dec.alu_op = AluSlt;
          FnJr: begin
            dec.cls     = ClsJr;
            dec.reg_dst = RegDstRt;
          end
          default: begin
            dec.cls     = ClsIllegal;
            dec.reg_dst = RegDstRt;
          end
        endcase
      end
      OpAddi: begin
        dec.cls         = ClsIAlu;
        dec.alu_op      = AluAdd;
        dec.alu_src_imm = 1'b1;
      end
      OpAddiu: begin
        dec.cls         = ClsIAlu;
        dec.alu_op      = AluAddu;
        dec.alu_src_imm = 1'b1;
        dec.imm_zext    = 1'b1;
      end
      OpAndi: begin
        dec.cls         = ClsIAlu;
        dec.alu_op      = AluAnd;
        dec.alu_src_imm = 1'b1;
        dec.imm_zext    = 1'b1;
      end
      OpOri: begin
        dec.cls         = ClsIAlu;
        dec.alu_op      = AluOr;
        dec.alu_src_imm = 1'b1;
        dec.imm_zext    = 1'b1;
      end
      OpSlti: begin
        dec.cls         = ClsIAlu;
        dec.alu_op      = AluSlt;
        dec.alu_src_imm = 1'b1;
      end
      OpLw: begin
        dec.cls         = ClsLoad;
        dec.alu_src_imm = 1'b1;
        dec.wb_sel      = WbMem;
      end
      OpSw: begin
        dec.cls         = ClsStore;
        dec.alu_src_imm = 1'b1;
      end
      // Branches run rs-rt through the ALU so alu_zero/alu_neg are valid.
      OpBeq: begin
        dec.cls     = ClsBranch;
        dec.br_cond = BrEq;
        dec.alu_op  = AluSub;
      end
      OpBne: begin
        dec.cls     = ClsBranch;
        dec.br_cond = BrNe;
        dec.alu_op  = AluSub;
      end
      OpBgt: begin
        dec.cls     = ClsBranch;
        dec.br_cond = BrGt;
        dec.alu_op  = AluSub;
      end
      OpBge: begin
        dec.cls     = ClsBranch;
        dec.br_cond = BrGe;
        dec.alu_op  = AluSub;
      end
      OpBlt: begin
        dec.cls     = ClsBranch;
        dec.br_cond = BrLt;
        dec.alu_op  = AluSub;
      end
      OpBle: begin
        dec.cls     = ClsBranch;
        dec.br_cond = BrLe;
        dec.alu_op  = AluSub;
      end
      OpJ: dec.cls = ClsJump;
      OpJal: begin
        dec.cls     = ClsJal;
        dec.reg_dst = RegDstLink;
        dec.wb_sel  = WbPc;
      end
      default: dec.cls = ClsIllegal;
    endcase

    dec.illegal = (dec.cls == ClsIllegal);
  end

endmodule

// File: rtl/bubble_multicycle_ctrl.sv
// Multi-cycle control FSM for the BUBBLE processor.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and is the sole
// source of PC-advance and write enables.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   instr, instr_valid            - instruction word and its valid strobe
//   instr_req, ir_load            - fetch request, IR load strobe
//   alu_zero, alu_neg             - rs-rt compare flags in EXEC
//   mem_ready                     - data-memory access complete
//   alu_op, alu_src_imm, imm_zext - ALU controls
//   reg_dst, reg_write, wb_sel    - register-file controls
//   mem_read, mem_write           - data-memory controls
//   pc_en, pc_src                 - PC update strobe and source
//   retire, illegal               - per-instruction completion / fault pulses
//   retired_cnt                   - wrapping count of retire pulses
//   state                         - current FSM state (debug)
module bubble_multicycle_ctrl
  import bubble_ctrl_pkg::*;
#(
  parameter int unsigned RET_CNT_W = 16,
  parameter int unsigned LINK_REG  = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 instr_valid,
  output logic                 instr_req,
  output logic                 ir_load,
  input  logic                 alu_zero,
  input  logic                 alu_neg,
  input  logic                 mem_ready,
  output logic [3:0]           alu_op,
  output logic                 alu_src_imm,
  output logic                 imm_zext,
  output logic [1:0]           reg_dst,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 pc_en,
  output logic [1:0]           pc_src,
  output logic                 retire,
  output logic                 illegal,
  output logic [RET_CNT_W-1:0] retired_cnt,
  output logic [2:0]           state
);

  // The link index itself is applied by the register-file address mux; this
  // block only selects it through reg_dst.
  localparam int unsigned unused_link_reg = LINK_REG;

  state_e               state_q, state_d;
  logic [31:0]          ir_q;
  logic [RET_CNT_W-1:0] retired_cnt_q;
  decode_t              dec;
  logic                 br_taken;

  bubble_ctrl_decode u_decode (
    .ir  (ir_q),
    .dec (dec)
  );

  assign br_taken    = branch_taken(dec.br_cond, alu_zero, alu_neg);
  assign state       = state_q;
  assign retired_cnt = retired_cnt_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction register and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q          <= '0;
      retired_cnt_q <= '0;
    end else begin
      if (ir_load) begin
        ir_q <= instr;
      end
      if (retire) begin
        retired_cnt_q <= retired_cnt_q + RET_CNT_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = instr_valid ? StDecode : StFetch;
      StDecode: state_d = dec.illegal ? StFetch : StExec;
      StExec: begin
        if (dec.cls inside {ClsRAlu, ClsIAlu}) begin
          state_d = StWb;
        end else if (dec.cls inside {ClsLoad, ClsStore}) begin
          state_d = StMem;
        end else begin
          state_d = StFetch;
        end
      end
      StMem: begin
        if (!mem_ready) begin
          state_d = StMem;
        end else if (dec.cls == ClsLoad) begin
          state_d = StWb;
        end else begin
          state_d = StFetch;
        end
      end
      StWb:    state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Output logic: decoded from state and IR; only ir_load, the MEM completion
  // terms and the branch pc_src look at live inputs.
  always_comb begin
    instr_req   = 1'b0;
    ir_load     = 1'b0;
    alu_op      = AluAdd;
    alu_src_imm = 1'b0;
    imm_zext    = 1'b0;
    reg_dst     = RegDstRt;
    reg_write   = 1'b0;
    wb_sel      = WbAlu;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pc_en       = 1'b0;
    pc_src      = PcSeq;
    retire      = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      StFetch: begin
        instr_req = 1'b1;
        ir_load   = instr_valid;
      end
      StDecode: begin
        // An undecodable word is dropped: PC advances but nothing retires.
        if (dec.illegal) begin
          illegal = 1'b1;
          pc_en   = 1'b1;
        end
      end
      StExec: begin
        case (dec.cls)
          ClsRAlu, ClsIAlu, ClsLoad, ClsStore: begin
            alu_op      = dec.alu_op;
            alu_src_imm = dec.alu_src_imm;
            imm_zext    = dec.imm_zext;
          end
          ClsBranch: begin
            alu_op = dec.alu_op;
            pc_en  = 1'b1;
            pc_src = br_taken ? PcBranch : PcSeq;
            retire = 1'b1;
          end
          ClsJump: begin
            pc_en  = 1'b1;
            pc_src = PcJump;
            retire = 1'b1;
          end
          ClsJal: begin
            pc_en     = 1'b1;
            pc_src    = PcJump;
            retire    = 1'b1;
            reg_write = 1'b1;
            reg_dst   = dec.reg_dst;
            wb_sel    = dec.wb_sel;
          end
          ClsJr: begin
            pc_en  = 1'b1;
            pc_src = PcRs;
            retire = 1'b1;
          end
          default: ;
        endcase
      end
      StMem: begin
        if (dec.cls == ClsLoad) begin
          mem_read = 1'b1;
        end else if (dec.cls == ClsStore) begin
          mem_write = 1'b1;
          pc_en     = mem_ready;
          retire    = mem_ready;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        reg_dst   = dec.reg_dst;
        wb_sel    = dec.wb_sel;
        pc_en     = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bubble_multicycle_ctrl.sv
// Self-checking bench for bubble_multicycle_ctrl. A second instance with an
// 8-bit retire counter shares the stimulus so counter wrap is reached quickly.
module tb_bubble_multicycle_ctrl;
  import bubble_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid, alu_zero, alu_neg, mem_ready;
  logic        instr_req, ir_load, alu_src_imm, imm_zext, reg_write;
  logic        mem_read, mem_write, pc_en, retire, illegal;
  logic [3:0]  alu_op;
  logic [1:0]  reg_dst, wb_sel, pc_src;
  logic [15:0] retired_cnt;
  logic [2:0]  state;

  logic        u8_instr_req, u8_ir_load, u8_alu_src_imm, u8_imm_zext, u8_reg_write;
  logic        u8_mem_read, u8_mem_write, u8_pc_en, u8_retire, u8_illegal;
  logic [3:0]  u8_alu_op;
  logic [1:0]  u8_reg_dst, u8_wb_sel, u8_pc_src;
  logic [7:0]  cnt8;
  logic [2:0]  u8_state;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;
  logic [7:0]  exp_cnt8 = '0;

  always #5 clk = ~clk;

  bubble_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_req(instr_req), .ir_load(ir_load), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .imm_zext(imm_zext), .reg_dst(reg_dst), .reg_write(reg_write), .wb_sel(wb_sel),
    .mem_read(mem_read), .mem_write(mem_write), .pc_en(pc_en), .pc_src(pc_src),
    .retire(retire), .illegal(illegal), .retired_cnt(retired_cnt), .state(state)
  );

  bubble_multicycle_ctrl #(.RET_CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_req(u8_instr_req), .ir_load(u8_ir_load), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .mem_ready(mem_ready), .alu_op(u8_alu_op),
    .alu_src_imm(u8_alu_src_imm), .imm_zext(u8_imm_zext), .reg_dst(u8_reg_dst),
    .reg_write(u8_reg_write), .wb_sel(u8_wb_sel), .mem_read(u8_mem_read),
    .mem_write(u8_mem_write), .pc_en(u8_pc_en), .pc_src(u8_pc_src),
    .retire(u8_retire), .illegal(u8_illegal), .retired_cnt(cnt8), .state(u8_state)
  );

  // Expected behaviour of one instruction, derived from the ISA rules.
  typedef struct {
    int       lat;      // cycles from ir_load to final cycle, inclusive
    bit       ill;
    bit       wr;
    bit [1:0] rdst;
    bit [1:0] wsel;
    bit [1:0] psrc;
    bit       has_alu;
    bit [3:0] aluop;
    bit       src_imm;
    bit       zext;
    int       n_rd;
    int       n_mw;
  } exp_t;

  function automatic exp_t model(input logic [31:0] w, input bit z, input bit n,
                                 input int waits);
    exp_t e;
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    e = '{default: 0};
    e.lat = 2;
    e.ill = 1;
    case (op)
      6'h00: begin
        e.ill = 0; e.lat = 4; e.wr = 1; e.rdst = 1; e.has_alu = 1;
        case (fn)
          6'h20: e.aluop = AluAdd;
          6'h22: e.aluop = AluSub;
          6'h21: e.aluop = AluAddu;
          6'h23: e.aluop = AluSubu;
          6'h24: e.aluop = AluAnd;
          6'h25: e.aluop = AluOr;
          6'h00: e.aluop = AluSll;
          6'h02: e.aluop = AluSrl;
          6'h2A: e.aluop = AluSlt;
          6'h08: begin e.lat = 3; e.wr = 0; e.rdst = 0; e.has_alu = 0; e.psrc = 3; end
          default: begin e.ill = 1; e.lat = 2; e.wr = 0; e.rdst = 0; e.has_alu = 0; end
        endcase
      end
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A: begin
        e.ill = 0; e.lat = 4; e.wr = 1; e.has_alu = 1; e.src_imm = 1;
        case (op)
          6'h08:   e.aluop = AluAdd;
          6'h09:   begin e.aluop = AluAddu; e.zext = 1; end
          6'h0C:   begin e.aluop = AluAnd; e.zext = 1; end
          6'h0D:   begin e.aluop = AluOr; e.zext = 1; end
          default: e.aluop = AluSlt;
        endcase
      end
      6'h23: begin
        e.ill = 0; e.lat = 5 + waits; e.wr = 1; e.wsel = 1; e.has_alu = 1;
        e.aluop = AluAdd; e.src_imm = 1; e.n_rd = waits + 1;
      end
      6'h2B: begin
        e.ill = 0; e.lat = 4 + waits; e.has_alu = 1; e.aluop = AluAdd; e.src_imm = 1;
        e.n_mw = waits + 1;
      end
      6'h04: begin e.ill = 0; e.lat = 3; e.psrc = z ? 2'd1 : 2'd0; end
      6'h05: begin e.ill = 0; e.lat = 3; e.psrc = !z ? 2'd1 : 2'd0; end
      6'h07: begin e.ill = 0; e.lat = 3; e.psrc = (!z && !n) ? 2'd1 : 2'd0; end
      6'h0F: begin e.ill = 0; e.lat = 3; e.psrc = !n ? 2'd1 : 2'd0; end
      6'h06: begin e.ill = 0; e.lat = 3; e.psrc = n ? 2'd1 : 2'd0; end
      6'h1F: begin e.ill = 0; e.lat = 3; e.psrc = (n || z) ? 2'd1 : 2'd0; end
      6'h02: begin e.ill = 0; e.lat = 3; e.psrc = 2; end
      6'h03: begin e.ill = 0; e.lat = 3; e.psrc = 2; e.wr = 1; e.rdst = 2; e.wsel = 2; end
      default: ;
    endcase
    return e;
  endfunction

  // Feed one instruction and compare its whole cycle trace with the model.
  task automatic run_instr(input string nm, input logic [31:0] w, input bit z,
                           input bit n, input int waits);
    exp_t e;
    int fc, idle, n_ret, n_ill, n_wr, n_rd, n_mw, n_req;
    bit ret_fc;
    logic [1:0] psrc_fc, rdst_w, wsel_w;
    logic [3:0] op_ex;
    logic imm_ex, zext_ex;
    e = model(w, z, n, waits);
    fc = -1; n_ret = 0; n_ill = 0; n_wr = 0; n_rd = 0; n_mw = 0; n_req = 0;
    ret_fc = 0; psrc_fc = 'x; rdst_w = 'x; wsel_w = 'x; op_ex = 'x; imm_ex = 'x; zext_ex = 'x;
    idle = int'($urandom_range(0, 2));
    for (int i = 0; i < idle; i++) begin
      @(posedge clk); #1;
      instr_valid = 0; instr = $urandom; mem_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (state !== 3'd0 || instr_req !== 1'b1 || ir_load !== 1'b0 || pc_en !== 1'b0)
        begin errors++;
        $display("FAIL %s idle: state=%0d req=%b ld=%b pc_en=%b want 0/1/0/0", nm, state,
                 instr_req, ir_load, pc_en); end
    end
    for (int c = 0; c < e.lat + 6 && fc < 0; c++) begin
      @(posedge clk); #1;
      instr_valid = (c == 0);
      instr = (c == 0) ? w : $urandom;
      alu_zero = (c == 2) ? z : 1'($urandom);
      alu_neg  = (c == 2) ? n : 1'($urandom);
      if ((e.n_rd + e.n_mw) > 0 && c >= 3 && c <= 3 + waits) mem_ready = (c == 3 + waits);
      else mem_ready = 1'($urandom);
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (ir_load !== 1'b1 || instr_req !== 1'b1) begin errors++;
          $display("FAIL %s fetch: ir_load=%b instr_req=%b want 1/1", nm, ir_load, instr_req);
        end
      end else n_req += int'(instr_req);
      n_ret += int'(retire); n_ill += int'(illegal);
      n_rd += int'(mem_read); n_mw += int'(mem_write);
      if (reg_write === 1'b1) begin n_wr++; rdst_w = reg_dst; wsel_w = wb_sel; end
      if (c == 2) begin op_ex = alu_op; imm_ex = alu_src_imm; zext_ex = imm_zext; end
      if (pc_en === 1'b1) begin fc = c; psrc_fc = pc_src; ret_fc = (retire === 1'b1); end
    end
    checks++;
    if (fc != e.lat - 1) begin errors++;
      $display("FAIL %s latency %h: pc_en cycle=%0d want %0d (-1 = timeout)", nm, w, fc,
               e.lat - 1); end
    checks++;
    if (psrc_fc !== e.psrc) begin errors++;
      $display("FAIL %s pc_src %h: got %0d want %0d", nm, w, psrc_fc, e.psrc); end
    checks++;
    if (n_ret != int'(!e.ill) || ret_fc != !e.ill) begin errors++;
      $display("FAIL %s retire %h: count=%0d at_final=%b want %0d", nm, w, n_ret, ret_fc,
               !e.ill); end
    checks++;
    if (n_ill != int'(e.ill)) begin errors++;
      $display("FAIL %s illegal %h: count=%0d want %0d", nm, w, n_ill, e.ill); end
    checks++;
    if (n_wr != int'(e.wr)) begin errors++;
      $display("FAIL %s reg_write %h: count=%0d want %0d", nm, w, n_wr, e.wr); end
    if (e.wr) begin
      checks++;
      if (rdst_w !== e.rdst || wsel_w !== e.wsel) begin errors++;
        $display("FAIL %s wb %h: reg_dst=%0d wb_sel=%0d want %0d/%0d", nm, w, rdst_w,
                 wsel_w, e.rdst, e.wsel); end
    end
    checks++;
    if (n_rd != e.n_rd || n_mw != e.n_mw) begin errors++;
      $display("FAIL %s mem %h: read=%0d write=%0d cycles want %0d/%0d", nm, w, n_rd, n_mw,
               e.n_rd, e.n_mw); end
    if (e.has_alu) begin
      checks++;
      if (op_ex !== e.aluop || imm_ex !== e.src_imm || zext_ex !== e.zext) begin errors++;
        $display("FAIL %s alu %h: op=%0d imm=%b zext=%b want %0d/%b/%b", nm, w, op_ex,
                 imm_ex, zext_ex, e.aluop, e.src_imm, e.zext); end
    end
    checks++;
    if (n_req != 0) begin errors++;
      $display("FAIL %s instr_req outside fetch: %0d cycles want 0", nm, n_req); end
    if (!e.ill) begin exp_cnt = exp_cnt + 1'b1; exp_cnt8 = exp_cnt8 + 1'b1; end
    @(posedge clk); #1;
    instr_valid = 0; instr = $urandom; mem_ready = 1'($urandom);
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || pc_en !== 1'b0 || retired_cnt !== exp_cnt || cnt8 !== exp_cnt8)
      begin errors++;
      $display("FAIL %s after: state=%0d pc_en=%b cnt=%0d cnt8=%0d want 0/0/%0d/%0d", nm,
               state, pc_en, retired_cnt, cnt8, exp_cnt, exp_cnt8); end
  endtask

  task automatic test_reset();
    rst = 1; instr = '0; instr_valid = 0; alu_zero = 0; alu_neg = 0; mem_ready = 0;
    #2;
    checks++;
    if (instr_req !== 1'b1 || state !== 3'd0) begin errors++;
      $display("FAIL reset req/state: %b/%0d want 1/0", instr_req, state); end
    checks++;
    if ({ir_load, alu_op, alu_src_imm, imm_zext, reg_dst, reg_write, wb_sel, mem_read,
         mem_write, pc_en, pc_src, retire, illegal} !== '0) begin errors++;
      $display("FAIL reset outputs: some control nonzero want all 0"); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (retired_cnt !== 16'd0 || cnt8 !== 8'd0 || state !== 3'd0) begin errors++;
      $display("FAIL reset cnt: %0d/%0d state=%0d want 0/0/0", retired_cnt, cnt8, state); end
    rst = 0;
  endtask

  task automatic test_alu();
    logic [31:0] words [9] = '{32'h0022_0020, 32'h0022_1022, 32'h0002_1080, 32'h0002_1082,
                               32'h0022_102A, 32'h2022_0005, 32'h2422_0005, 32'h3022_000F,
                               32'h3422_000F};
    run_instr("add", 32'h0022_0020, 0, 0, 0);
    checks++;
    if (retired_cnt !== 16'd1) begin errors++;
      $display("FAIL add retired_cnt: %0d want 1", retired_cnt); end
    for (int i = 1; i < 9; i++) run_instr("alu", words[i], 1'($urandom), 1'($urandom), 0);
    run_instr("slti", 32'h2822_0005, 0, 1, 0);
  endtask

  task automatic test_load_store();
    run_instr("lw_wait3", 32'h8C20_000A, 0, 0, 3);
    run_instr("sw_wait2", 32'hAC20_000A, 0, 0, 2);
    run_instr("lw_nowait", 32'h8C20_000A, 0, 0, 0);
    run_instr("sw_nowait", 32'hAC20_000A, 0, 0, 0);
  endtask

  task automatic test_branch();
    logic [31:0] br [6] = '{32'h1001_000A, 32'h1422_000A, 32'h1C22_000A, 32'h3C22_000A,
                            32'h1822_000A, 32'h7C22_000A};
    run_instr("beq_taken", 32'h1001_000A, 1, 0, 0);
    run_instr("beq_not", 32'h1001_000A, 0, 0, 0);
    run_instr("ble_zero", 32'h7C22_000A, 1, 0, 0);
    for (int i = 0; i < 6; i++)
      for (int f = 0; f < 3; f++) run_instr("branch", br[i], f[0], f[1], 0);
  endtask

  task automatic test_jump();
    run_instr("j", 32'h0800_0002, 0, 0, 0);
    run_instr("jal", 32'h0C00_000A, 0, 0, 0);
    run_instr("jr", 32'h0000_0008, 0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("ill_op3f", 32'hFC00_0000, 0, 0, 0);
    run_instr("ill_funct", 32'h0022_003F, 0, 0, 0);
    run_instr("ill_op01", 32'h0400_0000, 0, 0, 0);
  endtask

  task automatic test_reset_mid_mem();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      instr_valid = (c == 0); instr = 32'hAC20_000A; mem_ready = 0;
    end
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1 || state !== 3'd3) begin errors++;
      $display("FAIL rst_mem pre: mem_write=%b state=%0d want 1/3", mem_write, state); end
    #2 rst = 1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || pc_en !== 1'b0 || retire !== 1'b0 || state !== 3'd0 ||
        instr_req !== 1'b1) begin errors++;
      $display("FAIL rst_mem: mem_write=%b pc_en=%b retire=%b state=%0d req=%b want 0/0/0/0/1",
               mem_write, pc_en, retire, state, instr_req); end
    checks++;
    if (retired_cnt !== 16'd0 || cnt8 !== 8'd0) begin errors++;
      $display("FAIL rst_mem cnt: %0d/%0d want 0/0", retired_cnt, cnt8); end
    exp_cnt = '0; exp_cnt8 = '0;
    @(negedge clk);
    rst = 0;
  endtask

  // Random back-to-back mix; enough retires to wrap the 8-bit instance.
  task automatic test_back_to_back();
    logic [11:0] kinds [22] = '{{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h21},
      {6'h00, 6'h23}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h00}, {6'h00, 6'h02},
      {6'h00, 6'h2A}, {6'h00, 6'h08}, {6'h08, 6'h11}, {6'h09, 6'h11}, {6'h0C, 6'h11},
      {6'h0D, 6'h11}, {6'h0A, 6'h11}, {6'h23, 6'h11}, {6'h2B, 6'h11}, {6'h04, 6'h11},
      {6'h1F, 6'h11}, {6'h02, 6'h11}, {6'h03, 6'h11}, {6'h3E, 6'h11}};
    logic [11:0] k;
    logic [31:0] w;
    for (int i = 0; i < 330; i++) begin
      k = kinds[$urandom_range(0, 21)];
      w = {k[11:6], 20'($urandom), k[5:0]};
      run_instr("rand", w, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time got limit want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_jump();
    test_illegal();
    test_reset_mid_mem();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
